// File: rtl/seq_shift_unit.sv
// seq_shift_unit -- iterative shift/rotate unit for the miniRISC execute stage.
//
// Shifts an operand by up to STEP bit positions per clock until the requested
// amount is consumed, then presents the result with a one-cycle done pulse.
// The control unit stalls the pipeline while busy is high.
//
// Parameters:
//   WIDTH   operand/result width (power of two, >= 8)
//   STEP    maximum bits shifted per cycle (power of two, 1..WIDTH)
//   SAMT_W  shift-amount width, derived from WIDTH
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       request, only honoured while idle
//   shift_type  00 SLL, 01 SRL, 10 SRA, 11 ROR
//   operand     value to shift, captured with start
//   shamt       shift amount 0..WIDTH-1, captured with start
//   busy        high from the accepting edge until done rises
//   done        one-cycle completion pulse
//   result      shifted value, held until the next completion or reset
//   zero        registered (result == 0)

module seq_shift_unit #(
  parameter  int WIDTH  = 32,
  parameter  int STEP   = 4,
  localparam int SAMT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        shift_type,
  input  logic [WIDTH-1:0]  operand,
  input  logic [SAMT_W-1:0] shamt,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              zero
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [1:0] T_SLL = 2'b00;
  localparam logic [1:0] T_SRL = 2'b01;
  localparam logic [1:0] T_SRA = 2'b10;
  localparam logic [1:0] T_ROR = 2'b11;

  // One extra bit so both STEP and WIDTH are representable as step amounts.
  localparam int              KW      = SAMT_W + 1;
  localparam logic [KW-1:0]   STEP_K  = KW'(STEP);
  localparam logic [KW-1:0]   WIDTH_K = KW'(WIDTH);

  logic [0:0]        state;
  logic [WIDTH-1:0]  acc;
  logic [1:0]        typ;
  logic [SAMT_W-1:0] rem;

  logic [KW-1:0]     k;
  logic [KW-1:0]     k_wrap;
  logic [WIDTH-1:0]  acc_next;
  logic [SAMT_W-1:0] rem_next;

  // Per-cycle step: k = min(STEP, rem). k <= rem < WIDTH, so rem_next never wraps.
  always_comb begin
    k        = ({1'b0, rem} < STEP_K) ? {1'b0, rem} : STEP_K;
    k_wrap   = WIDTH_K - k;
    rem_next = rem - k[SAMT_W-1:0];
    acc_next = acc;
    case (typ)
      T_SLL: acc_next = acc << k;
      T_SRL: acc_next = acc >> k;
      T_SRA: acc_next = $signed(acc) >>> k;
      // Low k bits wrap into the MSBs; only evaluated with k >= 1.
      T_ROR: acc_next = (acc >> k) | (acc << k_wrap);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
      acc    <= '0;
      typ    <= '0;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= operand;
            typ   <= shift_type;
            rem   <= shamt;
            busy  <= 1'b1;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (rem != '0) begin
            acc <= acc_next;
            rem <= rem_next;
          end else begin
            result <= acc;
            zero   <= (acc == '0);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: three builds (STEP=4, 1, 32) run against a
// reference model computed from shift semantics on widened vectors.
module tb_seq_shift_unit;

  localparam int W  = 32;
  localparam int NI = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NI-1:0]   start_v;
  logic [1:0]      shift_type;
  logic [W-1:0]    operand;
  logic [4:0]      shamt;
  logic [NI-1:0]   busy_v;
  logic [NI-1:0]   done_v;
  logic [NI-1:0]   zero_v;
  logic [W-1:0]    result_v [NI];

  logic [W-1:0]    prev [NI];
  int unsigned     n_checks = 0;
  int unsigned     n_errors = 0;

  always #5 clk = ~clk;

  seq_shift_unit #(.WIDTH(32), .STEP(4)) u_step4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .shift_type(shift_type),
    .operand(operand), .shamt(shamt), .busy(busy_v[0]), .done(done_v[0]),
    .result(result_v[0]), .zero(zero_v[0])
  );

  seq_shift_unit #(.WIDTH(32), .STEP(1)) u_step1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .shift_type(shift_type),
    .operand(operand), .shamt(shamt), .busy(busy_v[1]), .done(done_v[1]),
    .result(result_v[1]), .zero(zero_v[1])
  );

  seq_shift_unit #(.WIDTH(32), .STEP(32)) u_step32 (
    .clk(clk), .rst(rst), .start(start_v[2]), .shift_type(shift_type),
    .operand(operand), .shamt(shamt), .busy(busy_v[2]), .done(done_v[2]),
    .result(result_v[2]), .zero(zero_v[2])
  );

  function automatic int step_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  // Reference: shifts on 64-bit widened values (sign-extended for SRA,
  // duplicated for ROR) so fills and wraps fall out of plain arithmetic.
  function automatic logic [W-1:0] model(input logic [1:0] t, input logic [W-1:0] v,
                                         input int unsigned s);
    logic [2*W-1:0] x;
    case (t)
      2'b00:   x = {32'h0, v} << s;
      2'b01:   x = {32'h0, v} >> s;
      2'b10:   x = {{32{v[31]}}, v} >> s;
      default: x = {v, v} >> s;
    endcase
    return x[W-1:0];
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s/%0d/busy", tag, i), W'(busy_v[i]), 0);
      check_eq($sformatf("%s/%0d/done", tag, i), W'(done_v[i]), 0);
      check_eq($sformatf("%s/%0d/result", tag, i), result_v[i], prev[i]);
      check_eq($sformatf("%s/%0d/zero", tag, i), W'(zero_v[i]), W'(prev[i] == '0));
    end
  endtask

  // Issue one op on the instances in mask; called #1 after a posedge, so the
  // next posedge is the accepting edge. Checks busy/done/result/zero every
  // cycle against the expected latency. hold keeps start high through
  // instance 0's done cycle; chain returns on instance 0's done cycle.
  task automatic run_op(input logic [NI-1:0] mask, input logic [1:0] t,
                        input logic [W-1:0] v, input int unsigned s,
                        input bit hold, input bit chain, input string tag);
    int          lat [NI];
    int          maxlat;
    int          last;
    logic [W-1:0] exp;
    exp    = model(t, v, s);
    maxlat = 0;
    for (int i = 0; i < NI; i++) begin
      lat[i] = mask[i] ? (int'(s) + step_of(i) - 1) / step_of(i) + 1 : 0;
      if (lat[i] > maxlat) maxlat = lat[i];
    end
    start_v    = mask;
    shift_type = t;
    operand    = v;
    shamt      = 5'(s);
    @(posedge clk); #1;
    if (!hold) start_v = '0;
    // Inputs wander while busy; the unit must ignore them.
    shift_type = 2'($urandom);
    operand    = $urandom;
    shamt      = 5'($urandom);
    last = chain ? lat[0] : maxlat + 2;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      for (int i = 0; i < NI; i++) begin
        logic [W-1:0] er;
        er = (lat[i] != 0 && c >= lat[i]) ? exp : prev[i];
        check_eq($sformatf("%s/%0d/busy c%0d", tag, i, c), W'(busy_v[i]),
                 W'(lat[i] != 0 && c < lat[i]));
        check_eq($sformatf("%s/%0d/done c%0d", tag, i, c), W'(done_v[i]),
                 W'(lat[i] != 0 && c == lat[i]));
        check_eq($sformatf("%s/%0d/result c%0d", tag, i, c), result_v[i], er);
        check_eq($sformatf("%s/%0d/zero c%0d", tag, i, c), W'(zero_v[i]), W'(er == '0));
        if (lat[i] != 0 && c == lat[i]) prev[i] = exp;
      end
      if (hold && c == lat[0]) start_v = '0;
    end
  endtask

  initial begin
    rst        = 1'b1;
    start_v    = '0;
    shift_type = '0;
    operand    = '0;
    shamt      = '0;
    for (int i = 0; i < NI; i++) prev[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_all("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(3'b001, 2'b00, 32'h0000_0005, 2, 1'b0, 1'b0, "sll");
    check_eq("sll_spec", result_v[0], 32'h0000_0014);
    run_op(3'b001, 2'b01, 32'h0000_0045, 3, 1'b0, 1'b0, "srl");
    check_eq("srl_spec", result_v[0], 32'h0000_0008);
    run_op(3'b001, 2'b10, 32'hFFFF_FFFD, 31, 1'b0, 1'b0, "sra31");
    check_eq("sra31_spec", result_v[0], 32'hFFFF_FFFF);
    run_op(3'b001, 2'b11, 32'h8000_0001, 4, 1'b0, 1'b0, "ror");
    check_eq("ror_spec", result_v[0], 32'h1800_0000);
    run_op(3'b001, 2'b11, 32'h0000_002F, 0, 1'b0, 1'b0, "sh0");
    check_eq("sh0_spec", result_v[0], 32'h0000_002F);
    run_op(3'b111, 2'b10, 32'h8000_0000, 5, 1'b0, 1'b0, "sra5");
    for (int i = 0; i < NI; i++)
      check_eq($sformatf("sra5_spec/%0d", i), result_v[i], 32'hFC00_0000);
    run_op(3'b111, 2'b00, 32'h0000_0001, 31, 1'b0, 1'b0, "sll31");
    run_op(3'b111, 2'b00, 32'h0000_0000, 7, 1'b0, 1'b0, "zero_op");

    // start held high through a long op: one completion only.
    run_op(3'b001, 2'b10, 32'h8765_4321, 31, 1'b1, 1'b0, "hold");

    // start raised on the done cycle: second op accepted back-to-back.
    run_op(3'b001, 2'b01, 32'hF000_0000, 9, 1'b0, 1'b1, "b2b_a");
    run_op(3'b001, 2'b11, 32'h1234_5678, 13, 1'b0, 1'b0, "b2b_b");

    // Reset mid-flight abandons the op.
    start_v = 3'b001; shift_type = 2'b10; operand = 32'h8000_0000; shamt = 5'd31;
    @(posedge clk); #1;
    start_v = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) prev[i] = '0;
    check_idle_all("midrst");
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check_eq($sformatf("postrst/done c%0d", c), W'(done_v[0]), 0);
      check_eq($sformatf("postrst/busy c%0d", c), W'(busy_v[0]), 0);
    end

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] v;
      v = $urandom;
      if ($urandom_range(0, 7) == 0) v = '0;
      run_op(3'b111, 2'($urandom), v, $urandom_range(0, 31), 1'b0, 1'b0,
             $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
